ebpf_store_narrow: RTL and testbench
====================================

EBPF_STORE_NARROW -- requirements
Module: ebpf_store_narrow

Interface
REQ-001 Parameter ADDR_W, default 64: byte address width.
REQ-002 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port in_valid, input, 1: store request valid.
REQ-005 Port in_ready, output, 1: request accepted when in_valid and in_ready are both high.
REQ-006 Port in_addr, input, ADDR_W: byte address of the store.
REQ-007 Port in_data, input, 64: source register value; only the low size bytes are used.
REQ-008 Port in_size, input, 2: store size; 00 byte, 01 half, 10 word, 11 dword.
REQ-009 Port mem_we, output, 1: memory write beat valid.
REQ-010 Port mem_ready, input, 1: memory accepts the beat when mem_we and mem_ready are both high.
REQ-011 Port mem_addr, output, ADDR_W: 8-byte-aligned beat address; bits [2:0] are always 0.
REQ-012 Port mem_wdata, output, 64: lane-aligned write data.
REQ-013 Port mem_wstrb, output, 8: byte strobes.
REQ-014 Port store_done, output, 1: one-cycle pulse when the final beat of a store is accepted.
REQ-015 Port store_err, output, 1: one-cycle pulse when a request is dropped.

Function
REQ-016 The block SHALL narrow in_data to 1, 2, 4 or 8 bytes per in_size by truncation, discarding upper bits with no sign or overflow check.
REQ-017 Alignment SHALL form a 128-bit shifted data word: narrowed data << (in_addr[2:0]*8).
REQ-018 Alignment SHALL form a 16-bit strobe: ((1<<bytes)-1) << in_addr[2:0].
REQ-019 Beat 0 SHALL use the low 64 data bits and low 8 strobe bits.
REQ-020 Beat 1 SHALL use the high 64 data bits and high 8 strobe bits; a store crosses when the high strobe bits are nonzero.
REQ-021 The state machine SHALL have states IDLE, BEAT0 and BEAT1.
REQ-022 in_ready SHALL be high only in IDLE.
REQ-023 IDLE -> BEAT0 on acceptance; beat 0 data, strobe and address SHALL be registered.
REQ-024 mem_we SHALL be asserted in the cycle after acceptance (latency 1).
REQ-025 In BEAT0, mem_* SHALL be held stable until mem_ready; then go to BEAT1 if crossing, else IDLE with store_done pulsed.
REQ-026 Beat 1 address SHALL be the aligned address + 8, computed modulo 2^ADDR_W; aligned address all-ones&~7 SHALL wrap to 0.
REQ-027 In BEAT1, mem_* SHALL be held until mem_ready; then go to IDLE with store_done pulsed.
REQ-028 mem_we SHALL be low in IDLE.
REQ-029 mem_wdata bytes with a deasserted strobe SHALL be 0.
REQ-030 A new request SHALL NOT be accepted in the same cycle a store completes; the earliest next acceptance is the following cycle.

Reset
REQ-031 On rst, the state SHALL go to IDLE and mem_we, store_done and store_err SHALL be 0.
REQ-032 On rst, mem_addr, mem_wdata and mem_wstrb SHALL be 0.
REQ-033 rst asserted mid-store SHALL discard any pending beat without a store_done pulse.
REQ-034 in_ready SHALL be 0 while rst is high.

Configuration
REQ-035 With EBPF_STORE_MISALIGN_EN defined, crossing stores SHALL be split into two beats per REQ-020 to REQ-027.
REQ-036 Without EBPF_STORE_MISALIGN_EN, a crossing store SHALL be accepted, produce no beat, remain in IDLE, and pulse store_err in the cycle after acceptance.
REQ-037 Without EBPF_STORE_MISALIGN_EN, BEAT1 SHALL not exist.
REQ-038 Non-crossing stores SHALL behave identically in both builds.

Structure
REQ-039 Package ebpf_pkg SHALL hold the store-size enum (SZ_B, SZ_H, SZ_W, SZ_DW), the state enum, and the constant DW_BYTES = 8.
REQ-040 Combinational alignment (size mask, 128-bit shift, 16-bit strobe) SHALL be sub-module ebpf_store_lane_align; the FSM and registers SHALL be in ebpf_store_narrow.

Verification
REQ-041 Byte store, addr 0x1003, data 0xFFFF_FFFF_FFFF_FFAB -> one beat: addr 0x1000, wstrb 0x08, wdata 0x0000_0000_AB00_0000, then store_done.
REQ-042 Dword store, addr 0x2000, data 0x0123_4567_89AB_CDEF, mem_ready held low 3 cycles -> mem_* stable for 4 cycles, wstrb 0xFF, store_done on the accept cycle.
REQ-043 Word store, addr 0x3006, data 0xDDCC_BBAA (MISALIGN_EN) -> beat 0 at 0x3000, wstrb 0xC0, wdata 0xBBAA_0000_0000_0000; beat 1 at 0x3008, wstrb 0x03, wdata 0xDDCC.
REQ-044 Same stimulus as REQ-043 without MISALIGN_EN -> no mem_we, store_err pulse 1 cycle after acceptance, in_ready high the next cycle.
REQ-045 Half store, addr 0xFFFF_FFFF_FFFF_FFFF (MISALIGN_EN) -> beat 1 addr 0x0, wstrb 0x01.
REQ-046 rst asserted during BEAT1 with mem_ready low -> next cycle mem_we 0, in_ready 0 while rst is high, no store_done pulse.

Source files
------------

// File: rtl/ebpf_pkg.sv
// Shared types and constants for the eBPF narrow-store path.
// Optional feature macro: EBPF_STORE_MISALIGN_EN (adds the BEAT1 state).
package ebpf_pkg;

    localparam int DW_BYTES = 8;

    typedef enum logic [1:0] {
        SZ_B  = 2'b00,
        SZ_H  = 2'b01,
        SZ_W  = 2'b10,
        SZ_DW = 2'b11
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef EBPF_STORE_MISALIGN_EN
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
`else
        BEAT0 = 2'd1
`endif
    } state_e;

    // Number of bytes written by a store of the given size.
    function automatic logic [3:0] size_bytes(input store_size_e sz);
        case (sz)
            SZ_B:    size_bytes = 4'd1;
            SZ_H:    size_bytes = 4'd2;
            SZ_W:    size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/ebpf_store_lane_align.sv
// Combinational lane alignment: truncates the source value to the store size
// and shifts data and strobes onto the byte lanes selected by the address.
// With EBPF_STORE_MISALIGN_EN the upper (second-beat) half is also produced;
// otherwise only the first-beat half and the crossing indication exist.
module ebpf_store_lane_align
    import ebpf_pkg::*;
(
    input  logic [2:0]  byte_off,
    input  logic [63:0] data,
    input  logic [1:0]  size,
    output logic [63:0] lo_data,
    output logic [7:0]  lo_strb,
`ifdef EBPF_STORE_MISALIGN_EN
    output logic [63:0] hi_data,
    output logic [7:0]  hi_strb,
`endif
    output logic        crossing
);

    logic [63:0] narrowed;
    logic [3:0]  nbytes;
    logic [15:0] strb16;
`ifdef EBPF_STORE_MISALIGN_EN
    logic [127:0] data128;
`endif

    // Truncate to the store size, then place data and strobes on their lanes.
    always_comb begin
        nbytes = size_bytes(store_size_e'(size));
        case (store_size_e'(size))
            SZ_B:    narrowed = {56'd0, data[7:0]};
            SZ_H:    narrowed = {48'd0, data[15:0]};
            SZ_W:    narrowed = {32'd0, data[31:0]};
            default: narrowed = data;
        endcase
        strb16   = ((16'd1 << nbytes) - 16'd1) << byte_off;
        lo_strb  = strb16[7:0];
        crossing = |strb16[15:8];
`ifdef EBPF_STORE_MISALIGN_EN
        data128  = {64'd0, narrowed} << {byte_off, 3'b000};
        lo_data  = data128[63:0];
        hi_data  = data128[127:64];
        hi_strb  = strb16[15:8];
`else
        // Only the first beat is ever issued, so the 64-bit shift is exactly
        // the low half of the full 128-bit aligned word.
        lo_data  = narrowed << {byte_off, 3'b000};
`endif
    end

endmodule

// File: rtl/ebpf_store_narrow.sv
// Narrow store unit: accepts one byte/half/word/dword store and issues it as
// one (or, when split across a dword boundary, two) 8-byte-aligned beats.
// Optional feature macro: EBPF_STORE_MISALIGN_EN. When undefined, a store
// crossing a dword boundary is accepted, dropped and flagged on store_err.
module ebpf_store_narrow
    import ebpf_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [63:0]       in_data,
    input  logic [1:0]        in_size,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    output logic              store_done,
    output logic              store_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [63:0]       wdata_q, wdata_d;
    logic [7:0]        wstrb_q, wstrb_d;
    logic              err_q, err_d;

    logic [63:0]       al_lo_data;
    logic [7:0]        al_lo_strb;
    logic              al_crossing;
    logic              accept;
    logic [ADDR_W-1:0] aligned_addr;

`ifdef EBPF_STORE_MISALIGN_EN
    logic [63:0]       hi_wdata_q, hi_wdata_d;
    logic [7:0]        hi_wstrb_q, hi_wstrb_d;
    logic [63:0]       al_hi_data;
    logic [7:0]        al_hi_strb;
`endif

    ebpf_store_lane_align u_align (
        .byte_off (in_addr[2:0]),
        .data     (in_data),
        .size     (in_size),
        .lo_data  (al_lo_data),
        .lo_strb  (al_lo_strb),
`ifdef EBPF_STORE_MISALIGN_EN
        .hi_data  (al_hi_data),
        .hi_strb  (al_hi_strb),
`endif
        .crossing (al_crossing)
    );

    // Handshake outputs: ready only in IDLE outside reset; a beat is up in any other state.
    always_comb begin
        in_ready     = (state_q == IDLE) && !rst;
        mem_we       = (state_q != IDLE);
        accept       = in_valid && in_ready;
        aligned_addr = {in_addr[ADDR_W-1:3], 3'b000};
        mem_addr     = addr_q;
        mem_wdata    = wdata_q;
        mem_wstrb    = wstrb_q;
        store_err    = err_q;
    end

    // Next-state and beat register loading.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        err_d      = 1'b0;
        store_done = 1'b0;
`ifdef EBPF_STORE_MISALIGN_EN
        hi_wdata_d = hi_wdata_q;
        hi_wstrb_d = hi_wstrb_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
`ifdef EBPF_STORE_MISALIGN_EN
                    state_d    = BEAT0;
                    addr_d     = aligned_addr;
                    wdata_d    = al_lo_data;
                    wstrb_d    = al_lo_strb;
                    hi_wdata_d = al_hi_data;
                    hi_wstrb_d = al_hi_strb;
`else
                    if (al_crossing) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = BEAT0;
                        addr_d  = aligned_addr;
                        wdata_d = al_lo_data;
                        wstrb_d = al_lo_strb;
                    end
`endif
                end
            end
            BEAT0: begin
                if (mem_ready) begin
`ifdef EBPF_STORE_MISALIGN_EN
                    if (|hi_wstrb_q) begin
                        state_d = BEAT1;
                        addr_d  = addr_q + ADDR_W'(DW_BYTES);
                        wdata_d = hi_wdata_q;
                        wstrb_d = hi_wstrb_q;
                    end else begin
                        state_d    = IDLE;
                        store_done = !rst;
                    end
`else
                    state_d    = IDLE;
                    store_done = !rst;
`endif
                end
            end
`ifdef EBPF_STORE_MISALIGN_EN
            BEAT1: begin
                if (mem_ready) begin
                    state_d    = IDLE;
                    store_done = !rst;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State and beat registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            err_q      <= 1'b0;
`ifdef EBPF_STORE_MISALIGN_EN
            hi_wdata_q <= '0;
            hi_wstrb_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            err_q      <= err_d;
`ifdef EBPF_STORE_MISALIGN_EN
            hi_wdata_q <= hi_wdata_d;
            hi_wstrb_q <= hi_wstrb_d;
`endif
        end
    end

endmodule

// File: tb/tb_ebpf_store_narrow.sv
// Directed bench for ebpf_store_narrow. Follows the build's
// EBPF_STORE_MISALIGN_EN setting for the crossing-store scenarios.
module tb_ebpf_store_narrow;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_addr;
    logic [63:0] in_data;
    logic [1:0]  in_size;
    logic        mem_we;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        store_done;
    logic        store_err;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ebpf_store_narrow #(.ADDR_W(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .in_size    (in_size),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .store_done (store_done),
        .store_err  (store_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [63:0] a, input logic [63:0] d, input logic [1:0] s);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        in_size  = s;
    endtask

    task automatic check_beat(input string tag, input logic [63:0] a,
                              input logic [63:0] d, input logic [7:0] s);
        check({tag, "_we"},    {63'd0, mem_we}, 64'd1);
        check({tag, "_addr"},  mem_addr, a);
        check({tag, "_wdata"}, mem_wdata, d);
        check({tag, "_wstrb"}, {56'd0, mem_wstrb}, {56'd0, s});
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_addr   = '0;
        in_data   = '0;
        in_size   = 2'b00;
        mem_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_mem_we", {63'd0, mem_we}, 64'd0);
        check("rst_addr", mem_addr, 64'd0);
        check("rst_wdata", mem_wdata, 64'd0);
        check("rst_wstrb", {56'd0, mem_wstrb}, 64'd0);
        check("rst_done", {63'd0, store_done}, 64'd0);
        check("rst_err", {63'd0, store_err}, 64'd0);
        rst = 1'b0;
        #1;
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);

        // Byte store with garbage upper bits; unstrobed bytes must be zero
        req(64'h1003, 64'hFFFF_FFFF_FFFF_FFAB, 2'b00);
        tick();
        in_valid = 1'b0;
        check_beat("byte", 64'h1000, 64'h0000_0000_AB00_0000, 8'h08);
        check("byte_busy_ready", {63'd0, in_ready}, 64'd0);
        check("byte_no_done_yet", {63'd0, store_done}, 64'd0);
        mem_ready = 1'b1;
        #1;
        check("byte_done", {63'd0, store_done}, 64'd1);
        tick();
        check("byte_idle_we", {63'd0, mem_we}, 64'd0);
        check("byte_done_clr", {63'd0, store_done}, 64'd0);

        // Dword store with back-pressure: beat held stable for 4 cycles
        mem_ready = 1'b0;
        req(64'h2000, 64'h0123_4567_89AB_CDEF, 2'b11);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_beat("dw_hold", 64'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF);
            check("dw_hold_done", {63'd0, store_done}, 64'd0);
            tick();
        end
        // Next request waits on the input across the completing cycle
        req(64'h4002, 64'hFFFF_FFFF_FFFF_5566, 2'b01);
        mem_ready = 1'b1;
        #1;
        check_beat("dw_last", 64'h2000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        check("dw_done", {63'd0, store_done}, 64'd1);
        check("dw_done_ready", {63'd0, in_ready}, 64'd0);
        tick();
        check("b2b_idle_we", {63'd0, mem_we}, 64'd0);
        check("b2b_idle_ready", {63'd0, in_ready}, 64'd1);
        mem_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        check_beat("half", 64'h4000, 64'h0000_0000_5566_0000, 8'h0C);
        mem_ready = 1'b1;
        #1;
        check("half_done", {63'd0, store_done}, 64'd1);
        tick();

        // Word in the top lanes of a dword: not crossing
        req(64'h5004, 64'h1234_5678_9ABC_DEF0, 2'b10);
        tick();
        in_valid = 1'b0;
        check_beat("word_hi", 64'h5000, 64'h9ABC_DEF0_0000_0000, 8'hF0);
        check("word_hi_done", {63'd0, store_done}, 64'd1);
        tick();
        check("word_hi_idle", {63'd0, mem_we}, 64'd0);

`ifdef EBPF_STORE_MISALIGN_EN
        // Crossing word: two beats
        req(64'h3006, 64'h0000_0000_DDCC_BBAA, 2'b10);
        tick();
        in_valid = 1'b0;
        check_beat("x_w_b0", 64'h3000, 64'hBBAA_0000_0000_0000, 8'hC0);
        check("x_w_b0_done", {63'd0, store_done}, 64'd0);
        tick();
        check_beat("x_w_b1", 64'h3008, 64'h0000_0000_0000_DDCC, 8'h03);
        check("x_w_b1_done", {63'd0, store_done}, 64'd1);
        tick();
        check("x_w_idle", {63'd0, mem_we}, 64'd0);
        check("x_w_err", {63'd0, store_err}, 64'd0);

        // Crossing half at the top of the address space: beat 1 wraps to 0
        req(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_1234, 2'b01);
        tick();
        in_valid = 1'b0;
        check_beat("wrap_b0", 64'hFFFF_FFFF_FFFF_FFF8, 64'h3400_0000_0000_0000, 8'h80);
        tick();
        check_beat("wrap_b1", 64'h0, 64'h0000_0000_0000_0012, 8'h01);
        check("wrap_done", {63'd0, store_done}, 64'd1);
        tick();

        // Reset during BEAT1 with memory stalled
        req(64'h3006, 64'h0000_0000_DDCC_BBAA, 2'b10);
        tick();
        in_valid = 1'b0;
        tick();
        mem_ready = 1'b0;
        #1;
        check_beat("rst_b1_pre", 64'h3008, 64'h0000_0000_0000_DDCC, 8'h03);
`else
        // Crossing word is dropped with an error
        req(64'h3006, 64'h0000_0000_DDCC_BBAA, 2'b10);
        #1;
        check("x_w_ready", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid = 1'b0;
        check("x_w_no_we", {63'd0, mem_we}, 64'd0);
        check("x_w_err", {63'd0, store_err}, 64'd1);
        check("x_w_ready_next", {63'd0, in_ready}, 64'd1);
        tick();
        check("x_w_err_clr", {63'd0, store_err}, 64'd0);
        check("x_w_still_no_we", {63'd0, mem_we}, 64'd0);

        // Crossing half at the top of the address space is also dropped
        req(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_1234, 2'b01);
        tick();
        in_valid = 1'b0;
        check("wrap_no_we", {63'd0, mem_we}, 64'd0);
        check("wrap_err", {63'd0, store_err}, 64'd1);
        tick();

        // Reset during BEAT0 with memory stalled
        mem_ready = 1'b0;
        req(64'h5004, 64'h1234_5678_9ABC_DEF0, 2'b10);
        tick();
        in_valid = 1'b0;
        check_beat("rst_b0_pre", 64'h5000, 64'h9ABC_DEF0_0000_0000, 8'hF0);
`endif
        rst = 1'b1;
        #1;
        check("rst_mid_ready", {63'd0, in_ready}, 64'd0);
        check("rst_mid_done", {63'd0, store_done}, 64'd0);
        tick();
        check("rst_mid_we", {63'd0, mem_we}, 64'd0);
        check("rst_mid_ready2", {63'd0, in_ready}, 64'd0);
        check("rst_mid_done2", {63'd0, store_done}, 64'd0);
        check("rst_mid_addr", mem_addr, 64'd0);
        check("rst_mid_wstrb", {56'd0, mem_wstrb}, 64'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", {63'd0, in_ready}, 64'd1);
        check("post_rst_we", {63'd0, mem_we}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
